// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one in-order pipelined multiplier between N_REQ requesters.
// Define MULT_SHARE_ARB_ERR_EN to add the sticky err_orphan output.
module mult_share_arb #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ*32-1:0]        req_a,
  input  logic [N_REQ*32-1:0]        req_b,
  output logic [N_REQ-1:0]           req_rdy,
  output logic [31:0]                mul_din_a,
  output logic [31:0]                mul_din_b,
  output logic                       mul_din_vld,
  input  logic [63:0]                mul_dout,
  input  logic                       mul_dout_vld,
  output logic [N_REQ-1:0]           rsp_vld,
  output logic [63:0]                rsp_dout,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       busy
`ifdef MULT_SHARE_ARB_ERR_EN
  , output logic                     err_orphan
`endif
);

  localparam int TW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_OUT);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);
  localparam logic [TW:0]   N_W     = (TW+1)'(N_REQ);
  localparam logic [TW-1:0] LAST    = TW'(N_REQ - 1);

  logic [31:0]      op_a [N_REQ];
  logic [31:0]      op_b [N_REQ];
  logic [TW-1:0]    tag_mem [MAX_OUT];
  logic [TW-1:0]    rr_q, rr_d, grant_idx, head_tag;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]    cnt_q;
  logic [31:0]      din_a_q, din_b_q;
  logic             din_vld_q;
  logic [N_REQ-1:0] rsp_vld_q, head_oh;
  logic [63:0]      rsp_dout_q;
  logic [TW:0]      sum;
  logic             grant_any, push, pop, room;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign op_a[gi]    = req_a[32*gi +: 32];
      assign op_b[gi]    = req_b[32*gi +: 32];
      assign req_rdy[gi] = push & (grant_idx == TW'(gi));
      assign head_oh[gi] = (head_tag == TW'(gi));
    end
  endgenerate

  // A pop in the same cycle frees the slot the push needs, so a full FIFO can still grant.
  assign pop  = mul_dout_vld & (cnt_q != '0);
  assign room = (cnt_q < MAX_CNT) | pop;
  assign push = grant_any & room & rst_n;
  assign head_tag = tag_mem[rd_ptr_q];

  // Scan offsets from the far end so the one closest to rr_q wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (TW+1)'(k);
      if (sum >= N_W) sum = sum - N_W;
      if (req_vld[sum[TW-1:0]]) begin
        grant_idx = sum[TW-1:0];
        grant_any = 1'b1;
      end
    end
    rr_d = (grant_idx == LAST) ? '0 : grant_idx + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      din_a_q    <= '0;
      din_b_q    <= '0;
      din_vld_q  <= 1'b0;
      rsp_vld_q  <= '0;
      rsp_dout_q <= '0;
    end else begin
      din_vld_q <= push;
      if (push) begin
        din_a_q  <= op_a[grant_idx];
        din_b_q  <= op_b[grant_idx];
        rr_q     <= rr_d;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        rsp_vld_q  <= head_oh;
        rsp_dout_q <= mul_dout;
      end else begin
        rsp_vld_q <= '0;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + OW'(1);
        2'b01:   cnt_q <= cnt_q - OW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (mul_dout_vld && (cnt_q == '0)) err_q <= 1'b1;
  end
  assign err_orphan = err_q;
`endif

  assign mul_din_a   = din_a_q;
  assign mul_din_b   = din_b_q;
  assign mul_din_vld = din_vld_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_dout    = rsp_dout_q;
  assign outstanding = cnt_q;
  assign busy        = (cnt_q != '0) | din_vld_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: scoreboard of per-requester product queues plus a
// fixed-latency multiplier model. Honours MULT_SHARE_ARB_ERR_EN when defined.
module tb_mult_share_arb;
  localparam int N   = 4;
  localparam int MO  = 8;
  localparam int LAT = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_vld;
  logic [N*32-1:0]   req_a, req_b;
  logic [N-1:0]      req_rdy;
  logic [31:0]       mul_din_a, mul_din_b;
  logic              mul_din_vld;
  logic [63:0]       mul_dout;
  logic              mul_dout_vld;
  logic [N-1:0]      rsp_vld;
  logic [63:0]       rsp_dout;
  logic [3:0]        outstanding;
  logic              busy;
  logic              inject;
`ifdef MULT_SHARE_ARB_ERR_EN
  logic              err_orphan;
`endif

  always #5 clk = ~clk;

  mult_share_arb #(.N_REQ(N), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
    .mul_din_a(mul_din_a), .mul_din_b(mul_din_b), .mul_din_vld(mul_din_vld),
    .mul_dout(mul_dout), .mul_dout_vld(mul_dout_vld),
    .rsp_vld(rsp_vld), .rsp_dout(rsp_dout),
    .outstanding(outstanding), .busy(busy)
`ifdef MULT_SHARE_ARB_ERR_EN
    , .err_orphan(err_orphan)
`endif
  );

  // Multiplier model: in order, fixed LAT cycles, shares rst_n.
  logic [LAT-1:0] pv;
  logic [31:0]    pa [LAT];
  logic [31:0]    pb [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pv <= '0;
    else        pv <= {pv[LAT-2:0], mul_din_vld};
  end
  always @(posedge clk) begin
    pa[0] <= mul_din_a;
    pb[0] <= mul_din_b;
    for (int i = 1; i < LAT; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign mul_dout     = 64'(pa[LAT-1]) * 64'(pb[LAT-1]);
  assign mul_dout_vld = pv[LAT-1] | inject;

  int          checks = 0;
  int          errors = 0;
  int          rr_m;
  int          infl [$];
  logic [63:0] exp_q [N][$];
  logic [31:0] last_a, last_b;
  logic [63:0] last_rsp;
  logic        exp_err;
  int          max_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    infl.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    rr_m = 0; last_a = '0; last_b = '0; last_rsp = '0; exp_err = 1'b0;
  endtask

  // One clock: grant check mid-cycle, registered outputs checked just after the edge.
  task automatic cycle();
    int g, t;
    logic pop_m, room, exp_dvld;
    logic [N-1:0] exp_rdy, exp_rsp;
    logic [63:0] exp_dout;
    logic [31:0] a, b;
    @(negedge clk);
    if (!rst_n) model_clear();
    pop_m = rst_n && mul_dout_vld && (infl.size() > 0);
    room  = (infl.size() < MO) || pop_m;
    g = -1;
    if (rst_n && room)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_vld[(rr_m + k) % N]) g = (rr_m + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_rdy", req_rdy, exp_rdy);
    if (rst_n && mul_dout_vld && infl.size() == 0) exp_err = 1'b1;
    exp_rsp = '0;
    exp_dout = last_rsp;
    if (pop_m) begin
      t = infl.pop_front();
      exp_rsp[t] = 1'b1;
      exp_dout = exp_q[t].pop_front();
    end
    if (g >= 0) begin
      a = req_a[32*g +: 32];
      b = req_b[32*g +: 32];
      infl.push_back(g);
      exp_q[g].push_back(64'(a) * 64'(b));
      last_a = a; last_b = b;
      rr_m = (g + 1) % N;
    end
    exp_dvld = (g >= 0);
    @(posedge clk); #1;
    if (!rst_n) begin
      model_clear();
      exp_rsp = '0; exp_dout = '0; exp_dvld = 1'b0;
    end
    last_rsp = exp_dout;
    check("mul_din_vld", mul_din_vld, exp_dvld);
    check("mul_din_a", mul_din_a, last_a);
    check("mul_din_b", mul_din_b, last_b);
    check("rsp_vld", rsp_vld, exp_rsp);
    check("rsp_dout", rsp_dout, exp_dout);
    check("outstanding", outstanding, infl.size());
    check("busy", busy, (infl.size() != 0) || exp_dvld);
`ifdef MULT_SHARE_ARB_ERR_EN
    check("err_orphan", err_orphan, exp_err);
`endif
    if (int'(outstanding) > max_seen) max_seen = int'(outstanding);
  endtask

  initial begin
    rst_n = 1'b0; req_vld = '1; req_a = '0; req_b = '0; inject = 1'b0;
    model_clear();
    max_seen = 0;
    repeat (3) cycle();

    // Single request from requester 2
    rst_n = 1'b1; req_vld = '0; cycle();
    req_vld = 4'b0100; req_a[64 +: 32] = 32'd3; req_b[64 +: 32] = 32'd5;
    cycle();
    req_vld = '0;
    repeat (16) cycle();
    check("single_rsp_dout", rsp_dout, 64'd15);

    // All four valid for 8 cycles, starting from a fresh pointer
    rst_n = 1'b0; repeat (2) cycle(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'(i + 1);
      req_b[32*i +: 32] = 32'h1000;
    end
    req_vld = '1;
    repeat (8) cycle();
    req_vld = '0;
    repeat (20) cycle();

    // Full FIFO with requester 0 continuously valid
    max_seen = 0;
    req_vld = 4'b0001; req_a[0 +: 32] = 32'd7; req_b[0 +: 32] = 32'd9;
    repeat (40) cycle();
    req_vld = '0;
    repeat (20) cycle();
    check("max_outstanding", max_seen, MO);

    // Max operands from requester 1
    req_vld = 4'b0010; req_a[32 +: 32] = '1; req_b[32 +: 32] = '1;
    cycle();
    req_vld = '0;
    repeat (16) cycle();
    check("max_rsp_dout", rsp_dout, 64'hFFFF_FFFE_0000_0001);

    // Reset with five operations in flight, then an injected orphan
    req_vld = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      req_a[96 +: 32] = $urandom; req_b[96 +: 32] = $urandom;
      cycle();
    end
    req_vld = '0;
    check("inflight_before_reset", outstanding, 4'd5);
    rst_n = 1'b0; repeat (2) cycle(); rst_n = 1'b1;
    repeat (15) cycle();
    inject = 1'b1; cycle(); inject = 1'b0;
    repeat (3) cycle();
`ifdef MULT_SHARE_ARB_ERR_EN
    check("err_orphan_set", err_orphan, 1'b1);
`endif

    // Random soak
    repeat (2000) begin
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[32*i +: 32] = $urandom;
      end
      cycle();
    end
    req_vld = '0;
    repeat (30) cycle();
    check("drain_outstanding", outstanding, 4'd0);
    check("drain_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
